// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
//   Accuracy monitor for 8x8 approximate multipliers. Takes a stream of
//   (a, b, prod_approx) samples over valid/ready, recomputes a*b exactly and
//   accumulates, over a programmed number of samples:
//     err_cnt - samples whose approximate product differs from a*b
//     sum_ed  - sum of |a*b - prod_approx|, saturating at all-ones
//     max_ed  - largest |a*b - prod_approx| seen
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             one-cycle pulse; accepted in IDLE/DONE only
//   num_samples       samples in the run, latched on an accepted start
//   in_valid/in_ready sample handshake (transfer on in_valid && in_ready)
//   a, b              8-bit unsigned operands
//   prod_approx       16-bit product from the multiplier under test
//   busy              run in progress (RUN or DRAIN)
//   done              level, high in DONE until the next accepted start or rst
//   err_cnt, sum_ed, max_ed   metrics of the current/last run
//
// Pipeline: accept -> S1 (exact product) -> S2 (error distance) -> metrics.
// The last accept at edge T makes done visible after edge T+3.

module approx_mul_err_monitor #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      prod_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [15:0]      max_ed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             s1_valid_reg;
  logic [15:0]      s1_exact_reg;
  logic [15:0]      s1_approx_reg;

  logic             s2_valid_reg;
  logic             s2_neq_reg;
  logic [15:0]      s2_ed_reg;

  logic [CNT_W-1:0] err_cnt_reg;
  logic [ACC_W-1:0] sum_ed_reg;
  logic [15:0]      max_ed_reg;

  logic             start_ok;
  logic             accept;
  logic [CNT_W:0]   cnt_inc;
  logic             last_accept;
  logic [ACC_W:0]   sum_wide;
  logic [15:0]      ed_calc;

  // in_ready is a pure function of state and counter, so no path from in_valid.
  assign in_ready    = (state_reg == RUN) && (cnt_reg < num_reg);
  assign accept      = in_valid && in_ready;
  assign start_ok    = start && ((state_reg == IDLE) || (state_reg == DONE));
  // One extra bit so num_samples = all-ones still compares correctly.
  assign cnt_inc     = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
  assign last_accept = accept && (cnt_inc == {1'b0, num_reg});

  assign ed_calc  = (s1_exact_reg >= s1_approx_reg) ? (s1_exact_reg - s1_approx_reg)
                                                    : (s1_approx_reg - s1_exact_reg);
  assign sum_wide = {1'b0, sum_ed_reg} + {{(ACC_W-15){1'b0}}, s2_ed_reg};

  assign busy    = (state_reg == RUN) || (state_reg == DRAIN);
  assign done    = (state_reg == DONE);
  assign err_cnt = err_cnt_reg;
  assign sum_ed  = sum_ed_reg;
  assign max_ed  = max_ed_reg;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Both stages empty means the final sample has reached the metrics.
        if (!s1_valid_reg && !s2_valid_reg) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Run control: sample count and latched target
  always_ff @(posedge clk) begin
    if (rst) begin
      num_reg <= '0;
      cnt_reg <= '0;
    end else if (start_ok) begin
      num_reg <= num_samples;
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= cnt_inc[CNT_W-1:0];
    end
  end

  // S1: exact product and captured approximate product
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_exact_reg  <= '0;
      s1_approx_reg <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_exact_reg  <= 16'(a) * 16'(b);
        s1_approx_reg <= prod_approx;
      end
    end
  end

  // S2: error distance and mismatch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_neq_reg   <= 1'b0;
      s2_ed_reg    <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_ed_reg  <= ed_calc;
        s2_neq_reg <= (s1_exact_reg != s1_approx_reg);
      end
    end
  end

  // Metric accumulation; cleared when a new run is accepted. The pipeline is
  // always empty in IDLE/DONE, so clearing never races an in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
      sum_ed_reg  <= '0;
      max_ed_reg  <= '0;
    end else if (start_ok) begin
      err_cnt_reg <= '0;
      sum_ed_reg  <= '0;
      max_ed_reg  <= '0;
    end else if (s2_valid_reg) begin
      if (s2_neq_reg) begin
        err_cnt_reg <= err_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // Carry out of the widened add means overflow: stick at all-ones.
      sum_ed_reg <= sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
      if (s2_ed_reg > max_ed_reg) begin
        max_ed_reg <= s2_ed_reg;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// tb_approx_mul_err_monitor
//   Drives two monitors in parallel (ACC_W=32 and ACC_W=16) with the same
//   stimulus and compares handshake, status and metrics against a reference
//   model computed from the accepted sample list with plain arithmetic.

module tb_approx_mul_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod_approx;

  logic        in_ready_w, busy_w, done_w;
  logic [15:0] err_cnt_w, max_ed_w;
  logic [31:0] sum_ed_w;

  logic        in_ready_n, busy_n, done_n;
  logic [15:0] err_cnt_n, max_ed_n;
  logic [15:0] sum_ed_n;

  int n_vec = 0;
  int n_err = 0;

  // Pending sample values (used in order when non-empty), valid pattern, and
  // the list of samples the bench expects to have been accepted this run.
  int unsigned qa[$], qb[$], qp[$];
  bit          vpat[$];
  int unsigned acc_a[$], acc_b[$], acc_p[$];
  bit          pulse_mid;

  always #5 clk = ~clk;

  approx_mul_err_monitor #(.CNT_W(16), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
    .prod_approx(prod_approx), .busy(busy_w), .done(done_w),
    .err_cnt(err_cnt_w), .sum_ed(sum_ed_w), .max_ed(max_ed_w)
  );

  approx_mul_err_monitor #(.CNT_W(16), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_n), .a(a), .b(b),
    .prod_approx(prod_approx), .busy(busy_n), .done(done_n),
    .err_cnt(err_cnt_n), .sum_ed(sum_ed_n), .max_ed(max_ed_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input bit e_ready, input bit e_busy, input bit e_done);
    check({tag, ".in_ready32"}, 64'(in_ready_w), 64'(e_ready));
    check({tag, ".busy32"},     64'(busy_w),     64'(e_busy));
    check({tag, ".done32"},     64'(done_w),     64'(e_done));
    check({tag, ".in_ready16"}, 64'(in_ready_n), 64'(e_ready));
    check({tag, ".busy16"},     64'(busy_n),     64'(e_busy));
    check({tag, ".done16"},     64'(done_n),     64'(e_done));
  endtask

  // Reference: metrics straight from the accepted sample list.
  task automatic check_metrics(input string tag);
    longint unsigned s = 0, m = 0, e = 0, ex, ed, s32, s16;
    for (int i = 0; i < acc_a.size(); i++) begin
      ex = longint'(acc_a[i]) * longint'(acc_b[i]);
      ed = (ex >= acc_p[i]) ? ex - acc_p[i] : acc_p[i] - ex;
      if (ed != 0) e++;
      s += ed;
      if (ed > m) m = ed;
    end
    s32 = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
    s16 = (s > 64'hFFFF) ? 64'hFFFF : s;
    check({tag, ".err_cnt32"}, 64'(err_cnt_w), e);
    check({tag, ".sum_ed32"},  64'(sum_ed_w),  s32);
    check({tag, ".max_ed32"},  64'(max_ed_w),  m);
    check({tag, ".err_cnt16"}, 64'(err_cnt_n), e);
    check({tag, ".sum_ed16"},  64'(sum_ed_n),  s16);
    check({tag, ".max_ed16"},  64'(max_ed_n),  m);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input int n);
    start       = 1'b1;
    num_samples = 16'(n);
    @(negedge clk);
    start       = 1'b0;
    num_samples = 16'($urandom);
    acc_a.delete(); acc_b.delete(); acc_p.delete();
  endtask

  task automatic run(input int n, input string tag);
    int acc = 0;
    int cyc = 0;
    int pi  = 0;
    bit v;
    int unsigned sa, sb, sp;
    do_start(n);
    if (n == 0) begin
      check_ctl({tag, ".zero"}, 1'b0, 1'b0, 1'b1);
      check_metrics(tag);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_ctl({tag, ".zero2"}, 1'b0, 1'b0, 1'b1);
      return;
    end
    check({tag, ".busy_start"}, 64'(busy_w & busy_n), 64'd1);
    while (acc < n && cyc < 2000) begin
      check_ctl({tag, ".run"}, 1'b1, 1'b1, 1'b0);
      v = (pi < vpat.size()) ? vpat[pi] : bit'($urandom_range(0, 1));
      pi++;
      if (qa.size() > 0) begin
        sa = qa[0]; sb = qb[0]; sp = qp[0];
      end else begin
        sa = $urandom_range(0, 255);
        sb = $urandom_range(0, 255);
        sp = ($urandom_range(0, 1) == 1) ? sa * sb : $urandom_range(0, 65535);
      end
      in_valid    = v;
      a           = 8'(sa);
      b           = 8'(sb);
      prod_approx = 16'(sp);
      if (pulse_mid && cyc == 1) begin
        start       = 1'b1;
        num_samples = 16'd1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (v) begin
        acc++;
        acc_a.push_back(sa); acc_b.push_back(sb); acc_p.push_back(sp);
        if (qa.size() > 0) begin
          void'(qa.pop_front()); void'(qb.pop_front()); void'(qp.pop_front());
        end
      end
    end
    if (acc < n) check({tag, ".timeout"}, 64'd0, 64'd1);
    // Junk offered during drain must not be taken.
    in_valid    = 1'b1;
    a           = 8'hFF;
    b           = 8'hFF;
    prod_approx = 16'd1;
    for (int k = 0; k < 3; k++) begin
      check_ctl({tag, ".drain"}, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_ctl({tag, ".done"}, 1'b0, 1'b0, 1'b1);
    check_metrics(tag);
    vpat.delete();
  endtask

  task automatic push_sample(input int unsigned sa, input int unsigned sb, input int unsigned sp);
    qa.push_back(sa); qb.push_back(sb); qp.push_back(sp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; prod_approx = '0; pulse_mid = 1'b0;
    repeat (3) @(negedge clk);
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_metrics("reset");
    rst = 1'b0;
    @(negedge clk);
    check_ctl("idle", 1'b0, 1'b0, 1'b0);

    // Exact products: no error
    push_sample(3, 5, 15); push_sample(255, 255, 65025);
    push_sample(0, 200, 0); push_sample(12, 34, 408);
    run(4, "exact");

    // Two erroneous samples
    push_sample(255, 255, 0); push_sample(16, 16, 250);
    run(2, "err2");

    // Zero-length run
    run(0, "n0");

    // Gappy valid: 1,0,0,1,0,1
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run(3, "gaps");

    // Saturation of the 16-bit accumulator
    push_sample(255, 255, 0); push_sample(255, 255, 0); push_sample(255, 255, 0);
    run(3, "sat");

    // Reset mid-run after two accepts
    do_start(5);
    in_valid = 1'b1; a = 8'd200; b = 8'd100; prod_approx = 16'd7;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_ctl("abort", 1'b0, 1'b0, 1'b0);
    check_metrics("abort");
    @(negedge clk);
    check_ctl("abort2", 1'b0, 1'b0, 1'b0);
    check_metrics("abort2");
    push_sample(7, 9, 63);
    run(1, "post_rst");

    // start during RUN is ignored
    pulse_mid = 1'b1;
    run(3, "start_ign");
    pulse_mid = 1'b0;

    // Random runs
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(1, 20), $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
